status_reg_writer: RTL

- Producer end of the NZCV status interface. Captures ALU flags from the execute stage and holds them for one pending cycle.
- Commits them, masked per flag, into the architectural status register.
- Drives the 4-bit status word {N,Z,C,V} consumed by the condition-evaluation logic in decode/execute.
- Handles stall, flush and direct status writes (MSR-style), and flags read-after-write hazards.

---
 rtl/status_reg_writer.sv | 94 +++++++++
 1 files changed

// File: rtl/status_reg_writer.sv
// NZCV status producer: captures execute flags, commits them masked into sr_q.
// Optional forwarding of the pending entry to status_out under SR_BYPASS_EN.
module status_reg_writer #(
  parameter int         CNT_W    = 16,
  parameter logic [3:0] SR_RESET = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exe_valid,
  input  logic             exe_s,
  input  logic             exe_cond_pass,
  input  logic [3:0]       exe_flags,
  input  logic [3:0]       exe_mask,
  input  logic             stall,
  input  logic             flush,
  input  logic             msr_en,
  input  logic [3:0]       msr_data,
  input  logic             cond_use,
  output logic [3:0]       status_out,
  output logic [3:0]       sr_q,
  output logic             hazard,
  output logic [CNT_W-1:0] upd_cnt
);

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t     state;
  state_t     stateNxt;
  logic       pendValid;
  logic [3:0] pendFlags;
  logic [3:0] pendMask;
  logic [3:0] commitVal;
  logic [3:0] srNxt;
  logic       take;
  logic       commit;

  assign pendValid = (state == PENDING);

  assign take = exe_valid & exe_s & exe_cond_pass
              & ~stall & ~flush & (|exe_mask);

  assign commitVal = (sr_q & ~pendMask)
                   | (pendFlags & pendMask);

  always_comb begin
    stateNxt = IDLE;
    commit   = 1'b0;
    unique case (state)
      IDLE:    commit = 1'b0;
      PENDING: commit = 1'b1;
      default: commit = 1'b0;
    endcase
    if (take) stateNxt = PENDING;
  end

  // MSR is the younger write and wins over a same-cycle commit
  always_comb begin
    srNxt = sr_q;
    if (msr_en)      srNxt = msr_data;
    else if (commit) srNxt = commitVal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pendFlags <= 4'b0000;
      pendMask  <= 4'b0000;
      sr_q      <= SR_RESET;
      upd_cnt   <= '0;
    end else begin
      state <= stateNxt;
      sr_q  <= srNxt;
      if (take) begin
        pendFlags <= exe_flags;
        pendMask  <= exe_mask;
      end
      if (commit) upd_cnt <= upd_cnt + 1'b1;
    end
  end

`ifdef SR_BYPASS_EN
  logic unusedCondUse;
  assign unusedCondUse = cond_use;
  assign status_out = pendValid ? commitVal : sr_q;
  assign hazard     = 1'b0;
`else
  assign status_out = sr_q;
  assign hazard     = pendValid & cond_use;
`endif

endmodule
